regfile_arb: RTL

REGFILE_ARB -- requirements
Module: regfile_arb

---
 rtl/regfile_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_arb.sv
//------------------------------------------------------------------------------
// Module      : regfile_arb
// Description : Two-master round-robin arbiter in front of a single-port
//               register file, with a power-up / software clear sweep that
//               writes zero to every entry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_arb #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int DATA_D = 4
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              clr_,
  output logic              busy,
  input  logic              m0_req_,
  input  logic              m0_we_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_grnt_,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req_,
  input  logic              m1_we_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_grnt_,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ENTRY = ADDR_W'(DATA_D - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_d_in_q, rf_d_in_d;
  logic                rf_we_q, rf_we_d;
  logic                busy_q, busy_d;
  logic                m0_grnt_q, m0_grnt_d;
  logic                m1_grnt_q, m1_grnt_d;
  logic [DATA_W-1:0]   m0_rd_q, m0_rd_d;
  logic [DATA_W-1:0]   m1_rd_q, m1_rd_d;
  // 1 = m1 was granted last (also names the master owning the current ACCESS)
  logic                last_q, last_d;
  logic                pick_m1;

  // State and registered outputs; reset forces a fresh clear sweep from entry 0
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      rf_addr_q <= '0;
      rf_d_in_q <= '0;
      rf_we_q   <= 1'b0;
      busy_q    <= 1'b1;
      m0_grnt_q <= 1'b1;
      m1_grnt_q <= 1'b1;
      m0_rd_q   <= '0;
      m1_rd_q   <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_addr_q <= rf_addr_d;
      rf_d_in_q <= rf_d_in_d;
      rf_we_q   <= rf_we_d;
      busy_q    <= busy_d;
      m0_grnt_q <= m0_grnt_d;
      m1_grnt_q <= m1_grnt_d;
      m0_rd_q   <= m0_rd_d;
      m1_rd_q   <= m1_rd_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic: clear sweep, round-robin arbitration, one-cycle access
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rf_addr_d = rf_addr_q;
    rf_d_in_d = rf_d_in_q;
    rf_we_d   = rf_we_q;
    busy_d    = busy_q;
    m0_grnt_d = 1'b1;
    m1_grnt_d = 1'b1;
    m0_rd_d   = m0_rd_q;
    m1_rd_d   = m1_rd_q;
    last_d    = last_q;
    // m1 wins when alone, or on a tie when m0 was the last one served
    pick_m1   = !m1_req_ && (m0_req_ || !last_q);

    case (state_q)
      INIT: begin
        // rf_addr tracks the counter one edge ahead so the write lands on cnt_q
        cnt_d     = cnt_q + ADDR_W'(1);
        rf_addr_d = cnt_q + ADDR_W'(1);
        rf_d_in_d = '0;
        rf_we_d   = 1'b0;
        busy_d    = 1'b1;
        if (cnt_q == C_LAST_ENTRY) begin
          state_d = IDLE;
          rf_we_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (!clr_) begin
          state_d   = INIT;
          cnt_d     = '0;
          rf_addr_d = '0;
          rf_d_in_d = '0;
          rf_we_d   = 1'b0;
          busy_d    = 1'b1;
        end else if (!m0_req_ || !m1_req_) begin
          state_d = ACCESS;
          last_d  = pick_m1;
          if (pick_m1) begin
            rf_addr_d = m1_addr;
            rf_d_in_d = m1_wr_data;
            rf_we_d   = m1_we_;
            m1_grnt_d = 1'b0;
          end else begin
            rf_addr_d = m0_addr;
            rf_d_in_d = m0_wr_data;
            rf_we_d   = m0_we_;
            m0_grnt_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        // Reads capture the combinational regfile output at the closing edge
        if (rf_we_q) begin
          if (last_q) m1_rd_d = rf_d_out;
          else        m0_rd_d = rf_d_out;
        end
        rf_we_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  assign busy       = busy_q;
  assign m0_grnt_   = m0_grnt_q;
  assign m1_grnt_   = m1_grnt_q;
  assign m0_rd_data = m0_rd_q;
  assign m1_rd_data = m1_rd_q;
  assign rf_addr    = rf_addr_q;
  assign rf_d_in    = rf_d_in_q;
  assign rf_we_     = rf_we_q;

endmodule

`default_nettype wire
